// File: rtl/normal_eq_accumulator.sv
// normal_eq_accumulator
//
// Streaming front end of the least-squares quadratic trend fit
// y = c0 + c1*x + c2*x^2. Samples (x, y) arrive one per cycle. The block
// accumulates the power sums that make up the normal matrix A^T*A
// (N, sum x .. sum x^4) and the right-hand vector A^T*y (sum y,
// sum x*y, sum x^2*y). It hands one complete set downstream per
// out_valid/out_ready handshake.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   sample present on in_x / in_y
//   in_ready   block can accept a sample (high only while accumulating)
//   in_x       signed abscissa (time index), XW bits
//   in_y       signed ordinate (temperature), YW bits
//   in_last    final sample of the set, qualified by in_valid
//   out_valid  sums complete and held stable
//   out_ready  downstream accepts the sums
//   s0         unsigned sample count N
//   s1..s4     signed sum x, sum x^2, sum x^3, sum x^4   (ACC_W bits)
//   t0..t2     signed sum y, sum x*y, sum x^2*y          (ACC_W bits)
//   out_trunc  set ended because the sample counter saturated

module normal_eq_accumulator #(
  parameter  int XW    = 16,
  parameter  int YW    = 16,
  parameter  int CNT_W = 8,
  localparam int ACC_W = 4*XW + CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [XW-1:0]    in_x,
  input  logic signed [YW-1:0]    in_y,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        s0,
  output logic signed [ACC_W-1:0] s1,
  output logic signed [ACC_W-1:0] s2,
  output logic signed [ACC_W-1:0] s3,
  output logic signed [ACC_W-1:0] s4,
  output logic signed [ACC_W-1:0] t0,
  output logic signed [ACC_W-1:0] t1,
  output logic signed [ACC_W-1:0] t2,
  output logic                    out_trunc
);

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  // Count value that, once one more sample is accepted, fills the set.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << CNT_W) - 2);

  state_t state, state_next;

  logic             accept;
  logic             handshake;
  logic             sat_hit;
  logic [CNT_W-1:0] cnt;

  // Stage P1 registers
  logic                        p1_valid;
  logic signed [XW-1:0]        p1_x;
  logic signed [YW-1:0]        p1_y;
  logic signed [2*XW-1:0]      p1_x2;
  logic signed [XW+YW-1:0]     p1_xy;

  // Stage P2 registers
  logic                        p2_valid;
  logic signed [XW-1:0]        p2_x;
  logic signed [YW-1:0]        p2_y;
  logic signed [2*XW-1:0]      p2_x2;
  logic signed [XW+YW-1:0]     p2_xy;
  logic signed [3*XW-1:0]      p2_x3;
  logic signed [4*XW-1:0]      p2_x4;
  logic signed [2*XW+YW-1:0]   p2_x2y;

  // Full-width signed products; operands are sign-extended to the product
  // width first so no partial product can wrap.
  logic signed [2*XW-1:0]      x2_w;
  logic signed [XW+YW-1:0]     xy_w;
  logic signed [3*XW-1:0]      x3_w;
  logic signed [4*XW-1:0]      x4_w;
  logic signed [2*XW+YW-1:0]   x2y_w;

  assign x2_w  = (2*XW)'(in_x) * (2*XW)'(in_x);
  assign xy_w  = (XW+YW)'(in_x) * (XW+YW)'(in_y);
  assign x3_w  = (3*XW)'(p1_x2) * (3*XW)'(p1_x);
  assign x4_w  = (4*XW)'(p1_x2) * (4*XW)'(p1_x2);
  assign x2y_w = (2*XW+YW)'(p1_x2) * (2*XW+YW)'(p1_y);

  assign accept    = in_valid & in_ready;
  assign handshake = out_valid & out_ready;
  // The sample accepted while cnt == CNT_LAST brings the set to 2^CNT_W-1.
  assign sat_hit   = (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. DRAIN waits until both pipeline
  // stages are empty, which is exactly when the final sample has landed in
  // the accumulators, giving a fixed 3-cycle latency to out_valid.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (accept && (in_last || sat_hit)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!p1_valid && !p2_valid) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Acceptance counter and truncation flag. The counter runs at the input
  // so saturation is detected on the accepting edge, ahead of the pipeline.
  // A saturating sample that is also marked last is a normal end of set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      out_trunc <= 1'b0;
    end else if (handshake) begin
      cnt       <= '0;
      out_trunc <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + CNT_W'(1);
      if (sat_hit && !in_last) begin
        out_trunc <= 1'b1;
      end
    end
  end

  // Product pipeline: P1 squares the abscissa and forms x*y, P2 builds the
  // cubic, quartic and x^2*y terms from the P1 results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_x     <= '0;
      p1_y     <= '0;
      p1_x2    <= '0;
      p1_xy    <= '0;
      p2_valid <= 1'b0;
      p2_x     <= '0;
      p2_y     <= '0;
      p2_x2    <= '0;
      p2_xy    <= '0;
      p2_x3    <= '0;
      p2_x4    <= '0;
      p2_x2y   <= '0;
    end else begin
      p1_valid <= accept;
      if (accept) begin
        p1_x  <= in_x;
        p1_y  <= in_y;
        p1_x2 <= x2_w;
        p1_xy <= xy_w;
      end
      p2_valid <= p1_valid;
      if (p1_valid) begin
        p2_x   <= p1_x;
        p2_y   <= p1_y;
        p2_x2  <= p1_x2;
        p2_xy  <= p1_xy;
        p2_x3  <= x3_w;
        p2_x4  <= x4_w;
        p2_x2y <= x2y_w;
      end
    end
  end

  // Accumulators. The handshake clear can never coincide with an add since
  // the pipeline is empty in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
      t0 <= '0;
      t1 <= '0;
      t2 <= '0;
    end else if (handshake) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
      s4 <= '0;
      t0 <= '0;
      t1 <= '0;
      t2 <= '0;
    end else if (p2_valid) begin
      s0 <= s0 + CNT_W'(1);
      s1 <= s1 + ACC_W'(p2_x);
      s2 <= s2 + ACC_W'(p2_x2);
      s3 <= s3 + ACC_W'(p2_x3);
      s4 <= s4 + ACC_W'(p2_x4);
      t0 <= t0 + ACC_W'(p2_y);
      t1 <= t1 + ACC_W'(p2_xy);
      t2 <= t2 + ACC_W'(p2_x2y);
    end
  end

endmodule

// File: tb/tb_normal_eq_accumulator.sv
// tb_normal_eq_accumulator
//
// Self-checking bench for normal_eq_accumulator. A default-size instance
// runs the fixed vector table, bubble/stall, reset and randomized sets.
// A second instance with CNT_W=2 exercises counter saturation.

module tb_normal_eq_accumulator;

  localparam int XW     = 16;
  localparam int YW     = 16;
  localparam int CNT_W  = 8;
  localparam int ACC_W  = 4*XW + CNT_W;
  localparam int CNT2_W = 2;
  localparam int ACC2_W = 4*XW + CNT2_W;

  logic clk = 1'b0;
  logic rst;

  logic                    in_valid, in_last, out_ready;
  logic signed [XW-1:0]    in_x;
  logic signed [YW-1:0]    in_y;
  logic                    in_ready, out_valid, out_trunc;
  logic [CNT_W-1:0]        s0;
  logic signed [ACC_W-1:0] s1, s2, s3, s4, t0, t1, t2;

  logic                     in_valid2, in_last2, out_ready2;
  logic                     in_ready2, out_valid2, out_trunc2;
  logic [CNT2_W-1:0]        s0_2;
  logic signed [ACC2_W-1:0] s1_2, s2_2, s3_2, s4_2, t0_2, t1_2, t2_2;

  normal_eq_accumulator #(.XW(XW), .YW(YW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4),
    .t0(t0), .t1(t1), .t2(t2), .out_trunc(out_trunc)
  );

  normal_eq_accumulator #(.XW(XW), .YW(YW), .CNT_W(CNT2_W)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_x(in_x), .in_y(in_y),
    .in_last(in_last2), .out_valid(out_valid2), .out_ready(out_ready2),
    .s0(s0_2), .s1(s1_2), .s2(s2_2), .s3(s3_2), .s4(s4_2),
    .t0(t0_2), .t1(t1_2), .t2(t2_2), .out_trunc(out_trunc2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef logic signed [71:0] sum_t;

  typedef struct {
    int   n;
    int   xs[4];
    int   ys[4];
    sum_t e[8];
  } vec_t;

  vec_t vecs[3];
  int   qx[$];
  int   qy[$];

  task automatic checkOutput(input string name, input logic signed [127:0] act,
                             input logic signed [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: the eight sums taken directly from their definitions.
  task automatic refSums(output sum_t e[8]);
    sum_t x, y;
    for (int k = 0; k < 8; k++) e[k] = '0;
    for (int i = 0; i < qx.size(); i++) begin
      x = 72'(qx[i]);
      y = 72'(qy[i]);
      e[0] += 1;
      e[1] += x;
      e[2] += x * x;
      e[3] += x * x * x;
      e[4] += x * x * x * x;
      e[5] += y;
      e[6] += x * y;
      e[7] += x * x * y;
    end
  endtask

  task automatic checkSums(input string tag, input sum_t e[8], input logic et);
    checkOutput({tag, ".s0"}, $signed({1'b0, s0}), e[0]);
    checkOutput({tag, ".s1"}, s1, e[1]);
    checkOutput({tag, ".s2"}, s2, e[2]);
    checkOutput({tag, ".s3"}, s3, e[3]);
    checkOutput({tag, ".s4"}, s4, e[4]);
    checkOutput({tag, ".t0"}, t0, e[5]);
    checkOutput({tag, ".t1"}, t1, e[6]);
    checkOutput({tag, ".t2"}, t2, e[7]);
    checkOutput({tag, ".trunc"}, $signed({1'b0, out_trunc}), $signed({1'b0, et}));
  endtask

  // Feeds qx/qy, last flagged on the final sample. gaps: 0 none,
  // 1 one bubble before each sample, 2 random bubbles. Bubbles carry junk.
  // Returns on the falling edge after the out_valid rise edge.
  task automatic applyStimulus(input string tag, input int gaps);
    logic [3:0] hist;
    int nb;
    for (int i = 0; i < qx.size(); i++) begin
      nb = (gaps == 1) ? 1 : (gaps == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int b = 0; b < nb; b++) begin
        in_valid = 1'b0;
        in_x     = 16'($urandom);
        in_y     = 16'($urandom);
        in_last  = 1'b1;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_x     = 16'(qx[i]);
      in_y     = 16'(qy[i]);
      in_last  = (i == qx.size() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput({tag, ".rdy_low"}, $signed({1'b0, in_ready}), 0);
    hist[0] = out_valid;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      hist[k] = out_valid;
    end
    checkOutput({tag, ".ov_latency"}, $signed({1'b0, hist}), 8);
  endtask

  // Checks the result, holds out_ready low for 'stall' cycles while checking
  // stability, then handshakes and checks the clear.
  task automatic finishSet(input string tag, input int stall, input sum_t e[8],
                           input logic et);
    checkSums(tag, e, et);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      checkSums({tag, ".stall"}, e, et);
      checkOutput({tag, ".stall_rdy"}, $signed({1'b0, in_ready}), 0);
      checkOutput({tag, ".stall_ov"}, $signed({1'b0, out_valid}), 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, ".hs_ov"}, $signed({1'b0, out_valid}), 0);
    checkOutput({tag, ".hs_rdy"}, $signed({1'b0, in_ready}), 1);
    checkOutput({tag, ".hs_clear"},
                $signed({1'b0, |{s0, s1, s2, s3, s4, t0, t1, t2, out_trunc}}), 0);
  endtask

  task automatic loadVec(input int v);
    qx.delete();
    qy.delete();
    for (int i = 0; i < vecs[v].n; i++) begin
      qx.push_back(vecs[v].xs[i]);
      qy.push_back(vecs[v].ys[i]);
    end
  endtask

  sum_t zero8[8];
  sum_t em[8];
  int   accepted;
  int   waited;

  initial begin
    // Vector table: inputs and hand-derived expected sums.
    vecs[0].n = 3;
    vecs[0].xs = '{1, 2, 3, 0};
    vecs[0].ys = '{2, 4, 6, 0};
    vecs[0].e  = '{72'sd3, 72'sd6, 72'sd14, 72'sd36, 72'sd98, 72'sd12, 72'sd28, 72'sd72};
    vecs[1].n = 1;
    vecs[1].xs = '{-2, 0, 0, 0};
    vecs[1].ys = '{5, 0, 0, 0};
    vecs[1].e  = '{72'sd1, -72'sd2, 72'sd4, -72'sd8, 72'sd16, 72'sd5, -72'sd10, 72'sd20};
    vecs[2].n = 2;
    vecs[2].xs = '{-32768, -32768, 0, 0};
    vecs[2].ys = '{-32768, -32768, 0, 0};
    vecs[2].e  = '{72'sd2, -72'sd65536, 72'sd1 <<< 31, -(72'sd1 <<< 46), 72'sd1 <<< 61,
                   -72'sd65536, 72'sd1 <<< 31, -(72'sd1 <<< 46)};
    for (int k = 0; k < 8; k++) zero8[k] = '0;

    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_last2 = 1'b0; out_ready2 = 1'b0;
    in_x = '0; in_y = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkSums("reset", zero8, 1'b0);
    checkOutput("reset.rdy", $signed({1'b0, in_ready}), 1);
    checkOutput("reset.ov", $signed({1'b0, out_valid}), 0);

    $display("[TB] vector table");
    for (int v = 0; v < 3; v++) begin
      loadVec(v);
      applyStimulus($sformatf("vec%0d", v), 0);
      finishSet($sformatf("vec%0d", v), 0, vecs[v].e, 1'b0);
    end

    $display("[TB] bubbles and output stall");
    loadVec(0);
    applyStimulus("bubble", 1);
    finishSet("bubble", 5, vecs[0].e, 1'b0);

    $display("[TB] reset mid-set");
    loadVec(0);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_x = 16'(qx[i]); in_y = 16'(qy[i]); in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst.clear", $signed({1'b0, |{s0, s1, s2, s3, s4, t0, t1, t2, out_trunc}}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst.rdy", $signed({1'b0, in_ready}), 1);
    checkOutput("midrst.ov", $signed({1'b0, out_valid}), 0);
    applyStimulus("midrst", 0);
    finishSet("midrst", 0, vecs[0].e, 1'b0);

    $display("[TB] counter saturation");
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid2 = 1'b1; in_last2 = 1'b0; in_x = 16'sd1; in_y = 16'sd1;
      if (in_ready2) accepted++;
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    checkOutput("sat.accepted", accepted, 3);
    checkOutput("sat.rdy_low", $signed({1'b0, in_ready2}), 0);
    waited = 0;
    while (!out_valid2 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("sat.ov", $signed({1'b0, out_valid2}), 1);
    checkOutput("sat.s0", $signed({1'b0, s0_2}), 3);
    checkOutput("sat.s1", s1_2, 3);
    checkOutput("sat.t0", t0_2, 3);
    checkOutput("sat.trunc", $signed({1'b0, out_trunc2}), 1);
    out_ready2 = 1'b1;
    @(negedge clk);
    out_ready2 = 1'b0;
    checkOutput("sat.hs_rdy", $signed({1'b0, in_ready2}), 1);
    checkOutput("sat.hs_trunc", $signed({1'b0, out_trunc2}), 0);

    $display("[TB] randomized sets");
    for (int r = 0; r < 8; r++) begin
      qx.delete();
      qy.delete();
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
        qx.push_back(($urandom_range(0, 3) == 0) ? -32768 : int'($signed(16'($urandom))));
        qy.push_back(int'($signed(16'($urandom))));
      end
      refSums(em);
      applyStimulus($sformatf("rand%0d", r), 2);
      finishSet($sformatf("rand%0d", r), int'($urandom_range(0, 3)), em, 1'b0);
    end

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/normal_eq_accumulator.md
# normal_eq_accumulator

Streaming front end of the least-squares temperature-trend fit. It accepts (time, temperature) samples one per cycle and accumulates the power sums of a quadratic fit y = c0 + c1·x + c2·x². From those sums the 3×3 normal matrix A^T·A and the right-hand vector A^T·y are formed. It sits directly upstream of the matrix-inversion stage, which consumes its sums after one valid/ready handshake per data set.

## Interface
- XW, 16: width of signed sample abscissa `in_x` (time index).
- YW, 16: width of signed sample ordinate `in_y` (temperature).
- CNT_W, 8: sample counter width; a set holds at most 2^CNT_W−1 samples.
- Derived, fixed: ACC_W = 4·XW + CNT_W (72 at defaults), the width of every sum output.
- clk  input  1  Sole clock; everything samples on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- in_valid  input  1  Sample present on `in_x`/`in_y`.
- in_ready  output  1  Block can accept a sample.
- in_x  input  XW  Signed sample abscissa.
- in_y  input  YW  Signed sample ordinate.
- in_last  input  1  Qualified by `in_valid`; marks the final sample of the set.
- out_valid  output  1  Sums are complete and held stable.
- out_ready  input  1  Inversion stage accepts the sums.
- s0  output  CNT_W  Unsigned sample count N.
- s1, s2, s3, s4  output  ACC_W each  Signed Σx, Σx², Σx³, Σx⁴.
- t0, t1, t2  output  ACC_W each  Signed Σy, Σx·y, Σx²·y.
- out_trunc  output  1  Set was force-terminated by counter saturation.

## Operation
- States:
  - ACCUM: reset state; `in_ready`=1.
  - DRAIN: `in_ready`=0; the pipeline empties.
  - DONE: `in_ready`=0; `out_valid`=1.
- A sample is accepted when `in_valid` and `in_ready` are both high. Gaps in `in_valid` are allowed and do not disturb the sums.
- Pipeline stage P1 registers x, y, x² and x·y. All products are signed and full width.
- Pipeline stage P2 registers x³ = x²·x, x⁴ = x²·x², x²·y, plus passthroughs.
- Stage A adds the P2 products, sign-extended to ACC_W, into the accumulators. `s0` increments once per accepted sample.
- The accumulators cannot overflow: |x⁴|·(2^CNT_W−1) < 2^(ACC_W−1).
- Terminating a set:
  - An accepted sample with `in_last`=1 moves ACCUM to DRAIN.
  - An accepted sample that brings the count to 2^CNT_W−1 also moves ACCUM to DRAIN, even with `in_last`=0. In that case `out_trunc` is set to 1; otherwise it is 0.
- DRAIN moves to DONE once the final sample has been added to the accumulators.
- DONE holds all outputs stable while `out_ready`=0.
- On the out handshake (`out_valid` & `out_ready`): all accumulators, `s0` and `out_trunc` clear, and the state returns to ACCUM.
- Reset (any time, including mid-set or in DONE): state goes to ACCUM, pipeline valids, accumulators and all outputs go to 0, and `in_ready` goes to 1 after release. The partial set is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `s0`..`s4`=0, `t0`..`t2`=0, `out_trunc`=0.
- Last sample accepted at edge N:
  - `in_ready` is 0 from just after edge N.
  - `out_valid` is 1 from just after edge N+3 (pipeline latency is 3 cycles).
- Out handshake at edge M: `out_valid`=0 and `in_ready`=1 just after edge M. Sums read 0 from that point.
- No new sample is accepted in the handshake cycle itself, so data sets never overlap.
- Throughput: one sample per cycle within a set. The set-to-set overhead is 4 cycles plus any `out_ready` stall.
- `in_x`, `in_y` and `in_last` are don't-care when `in_valid`=0.

## Test plan
- Samples (1,2), (2,4), (3,6), with `in_last` on the third → s0=3, s1=6, s2=14, s3=36, s4=98, t0=12, t1=28, t2=72, `out_trunc`=0. `out_valid` rises 3 cycles after the last accept.
- Single sample (−2,5) with `in_last` → s0=1, s1=−2, s2=4, s3=−8, s4=16, t0=5, t1=−10, t2=20. Checks sign handling.
- Two samples x=−32768, y=−32768, second with `in_last` → s2=2^31, s3=−2^46, s4=2^61, t2=−2^46. No wrap.
- `in_valid` bubbles between samples, and `out_ready` held low 5 cycles in DONE:
  - Sums are identical to the gap-free run.
  - Outputs stay stable and `in_ready`=0 throughout the stall.
  - Handshake then clears the sums and re-opens input.
- CNT_W=2, five samples x=1, y=1 presented with no `in_last` → exactly 3 accepted, then `in_ready`=0. Result s0=3, s1=3, t0=3, `out_trunc`=1.
- `rst` pulsed asynchronously after 2 of 3 samples, then a fresh set (1,2), (2,4), (3,6) → the results match scenario 1 exactly, with no residue from the discarded set.
